// File: rtl/mcycle_arbiter_pkg.sv
// Shared encodings for the multicycle arbiter: request opcodes, unit
// operation codes, FSM states, and the opcode decode helpers.
package mcycle_arbiter_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        MC_MUL_S = 2'b00,
        MC_MUL_U = 2'b01,
        MC_DIV_S = 2'b10,
        MC_DIV_U = 2'b11
    } mc_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // MULHSU has no unit encoding; it never reaches the unit, so any code works.
    function automatic mc_op_e op_to_mc(input op_e op);
        case (op)
            OP_MULHU:        return MC_MUL_U;
            OP_DIV, OP_REM:  return MC_DIV_S;
            OP_DIVU, OP_REMU: return MC_DIV_U;
            default:         return MC_MUL_S;
        endcase
    endfunction

    // High word / remainder comes back on result2.
    function automatic logic op_sel_hi(input op_e op);
        return (op == OP_MULH) || (op == OP_MULHU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Remembers which port was granted last and
// favours the other one when both request at once.
module rr_arb2 (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_q;
    logic last_d;

    // Grant decode and pointer update on an accepted grant.
    always_comb begin
        grant  = 2'b00;
        last_d = last_q;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        if (advance && (grant != 2'b00)) begin
            last_d = grant[1];
        end
    end

    // Last-granted pointer; port 1 counts as last after reset so port 0 goes first.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mcycle_arbiter.sv
// Two-port front end for a shared multicycle mul/div unit. Resolves the
// trivial cases and repeat operands locally, otherwise drives the unit.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready to accept one request from the granted port
// ST_START | mc_start pulsed, operands presented to the unit
// ST_WAIT  | waiting for mc_busy to drop, then capture results
// ST_RESP  | response held until resp_ready
module mcycle_arbiter
    import mcycle_arbiter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAGW  = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [5:0]          req_op,
    input  logic [2*WIDTH-1:0]  req_a,
    input  logic [2*WIDTH-1:0]  req_b,
    input  logic [2*TAGW-1:0]   req_tag,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_id,
    output logic [TAGW-1:0]     resp_tag,
    output logic [WIDTH-1:0]    resp_data,
    output logic                resp_err,
    output logic                mc_start,
    output logic [1:0]          mc_op,
    output logic [WIDTH-1:0]    mc_op1,
    output logic [WIDTH-1:0]    mc_op2,
    input  logic [WIDTH-1:0]    mc_result1,
    input  logic [WIDTH-1:0]    mc_result2,
    input  logic                mc_busy
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  op1_q, op1_d;
    logic [WIDTH-1:0]  op2_q, op2_d;
    mc_op_e            mc_op_q, mc_op_d;
    logic              sel_hi_q, sel_hi_d;
    logic              resp_id_q, resp_id_d;
    logic [TAGW-1:0]   resp_tag_q, resp_tag_d;
    logic [WIDTH-1:0]  resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;
    logic              cache_valid_q, cache_valid_d;
    logic [WIDTH-1:0]  cache_a_q, cache_a_d;
    logic [WIDTH-1:0]  cache_b_q, cache_b_d;
    mc_op_e            cache_op_q, cache_op_d;
    logic [WIDTH-1:0]  cache_r1_q, cache_r1_d;
    logic [WIDTH-1:0]  cache_r2_q, cache_r2_d;

    logic [1:0]        arb_req;
    logic [1:0]        grant;
    logic              accept;
    logic              gnt_id;
    op_e               in_op;
    logic [WIDTH-1:0]  in_a;
    logic [WIDTH-1:0]  in_b;
    logic [TAGW-1:0]   in_tag;
    mc_op_e            in_mc;
    logic              in_hi;
    logic              in_is_div;
    logic              in_ovf;
    logic              hit;

    // Requests only compete while idle and out of reset, so ready is zero otherwise.
    assign arb_req = (state_q == ST_IDLE && RESET) ? req_valid : 2'b00;

    rr_arb2 u_rr_arb2 (
        .CLK     (CLK),
        .RESET   (RESET),
        .req     (arb_req),
        .advance (accept),
        .grant   (grant)
    );

    assign req_ready = grant;
    assign accept    = |grant;
    assign gnt_id    = grant[1];

    assign in_op     = op_e'(gnt_id ? req_op[5:3] : req_op[2:0]);
    assign in_a      = gnt_id ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
    assign in_b      = gnt_id ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
    assign in_tag    = gnt_id ? req_tag[2*TAGW-1:TAGW] : req_tag[TAGW-1:0];
    assign in_mc     = op_to_mc(in_op);
    assign in_hi     = op_sel_hi(in_op);
    assign in_is_div = in_op[2];
    assign in_ovf    = ((in_op == OP_DIV) || (in_op == OP_REM))
                       && (in_a == MIN_NEG) && (in_b == {WIDTH{1'b1}});
    assign hit       = cache_valid_q && (cache_a_q == in_a) && (cache_b_q == in_b)
                       && (cache_op_q == in_mc);

    // Next-state, response and cache update.
    always_comb begin
        state_d       = state_q;
        op1_d         = op1_q;
        op2_d         = op2_q;
        mc_op_d       = mc_op_q;
        sel_hi_d      = sel_hi_q;
        resp_id_d     = resp_id_q;
        resp_tag_d    = resp_tag_q;
        resp_data_d   = resp_data_q;
        resp_err_d    = resp_err_q;
        cache_valid_d = cache_valid_q;
        cache_a_d     = cache_a_q;
        cache_b_d     = cache_b_q;
        cache_op_d    = cache_op_q;
        cache_r1_d    = cache_r1_q;
        cache_r2_d    = cache_r2_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    resp_id_d  = gnt_id;
                    resp_tag_d = in_tag;
                    resp_err_d = 1'b0;
                    state_d    = ST_RESP;
                    if (in_op == OP_MULHSU) begin
                        resp_data_d = '0;
                        resp_err_d  = 1'b1;
                    end else if (in_is_div && (in_b == '0)) begin
                        resp_data_d = in_hi ? in_a : {WIDTH{1'b1}};
                    end else if (in_ovf) begin
                        resp_data_d = in_hi ? '0 : in_a;
                    end else if (hit) begin
                        resp_data_d = in_hi ? cache_r2_q : cache_r1_q;
                    end else begin
                        op1_d    = in_a;
                        op2_d    = in_b;
                        mc_op_d  = in_mc;
                        sel_hi_d = in_hi;
                        state_d  = ST_START;
                    end
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!mc_busy) begin
                    cache_valid_d = 1'b1;
                    cache_a_d     = op1_q;
                    cache_b_d     = op2_q;
                    cache_op_d    = mc_op_q;
                    cache_r1_d    = mc_result1;
                    cache_r2_d    = mc_result2;
                    resp_data_d   = sel_hi_q ? mc_result2 : mc_result1;
                    state_d       = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, operand, response and cache registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q       <= ST_IDLE;
            op1_q         <= '0;
            op2_q         <= '0;
            mc_op_q       <= MC_MUL_S;
            sel_hi_q      <= 1'b0;
            resp_id_q     <= 1'b0;
            resp_tag_q    <= '0;
            resp_data_q   <= '0;
            resp_err_q    <= 1'b0;
            cache_valid_q <= 1'b0;
            cache_a_q     <= '0;
            cache_b_q     <= '0;
            cache_op_q    <= MC_MUL_S;
            cache_r1_q    <= '0;
            cache_r2_q    <= '0;
        end else begin
            state_q       <= state_d;
            op1_q         <= op1_d;
            op2_q         <= op2_d;
            mc_op_q       <= mc_op_d;
            sel_hi_q      <= sel_hi_d;
            resp_id_q     <= resp_id_d;
            resp_tag_q    <= resp_tag_d;
            resp_data_q   <= resp_data_d;
            resp_err_q    <= resp_err_d;
            cache_valid_q <= cache_valid_d;
            cache_a_q     <= cache_a_d;
            cache_b_q     <= cache_b_d;
            cache_op_q    <= cache_op_d;
            cache_r1_q    <= cache_r1_d;
            cache_r2_q    <= cache_r2_d;
        end
    end

    assign mc_start   = (state_q == ST_START);
    assign resp_valid = (state_q == ST_RESP);
    assign mc_op      = mc_op_q;
    assign mc_op1     = op1_q;
    assign mc_op2     = op2_q;
    assign resp_id    = resp_id_q;
    assign resp_tag   = resp_tag_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mcycle_arbiter.sv
// Bench for mcycle_arbiter: behavioural multicycle unit, ISA reference
// model feeding a scoreboard, and checks on latency, hold and mc_start use.
module tb_mcycle_arbiter;
    import mcycle_arbiter_pkg::*;

    localparam int WIDTH    = 32;
    localparam int TAGW     = 4;
    localparam int BUSY_CYC = 4;
    // Cycles from the mc_start cycle to the first cycle with mc_busy low.
    localparam int UNIT_LAT = BUSY_CYC + 1;

    logic                CLK = 1'b0;
    logic                RESET;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [5:0]          req_op;
    logic [2*WIDTH-1:0]  req_a;
    logic [2*WIDTH-1:0]  req_b;
    logic [2*TAGW-1:0]   req_tag;
    logic                resp_valid;
    logic                resp_ready;
    logic                resp_id;
    logic [TAGW-1:0]     resp_tag;
    logic [WIDTH-1:0]    resp_data;
    logic                resp_err;
    logic                mc_start;
    logic [1:0]          mc_op;
    logic [WIDTH-1:0]    mc_op1;
    logic [WIDTH-1:0]    mc_op2;
    logic [WIDTH-1:0]    mc_result1;
    logic [WIDTH-1:0]    mc_result2;
    logic                mc_busy;

    mcycle_arbiter #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_tag   (resp_tag),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .mc_start   (mc_start),
        .mc_op      (mc_op),
        .mc_op1     (mc_op1),
        .mc_op2     (mc_op2),
        .mc_result1 (mc_result1),
        .mc_result2 (mc_result2),
        .mc_busy    (mc_busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;
    int start_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural multicycle unit ----------------
    function automatic logic [63:0] unit_calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ps;
        logic [63:0]        pu;
        logic [31:0]        q;
        logic [31:0]        r;
        ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        pu = {32'd0, a} * {32'd0, b};
        q = '0;
        r = '0;
        case (op)
            2'b00: return ps;
            2'b01: return pu;
            2'b10: begin
                if (b != 0 && !(a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
                    q = $signed(a) / $signed(b);
                    r = $signed(a) % $signed(b);
                end
                return {r, q};
            end
            default: begin
                if (b != 0) begin
                    q = a / b;
                    r = a % b;
                end
                return {r, q};
            end
        endcase
    endfunction

    logic        u_busy = 1'b0;
    int          u_cnt  = 0;
    logic [63:0] u_res  = '0;

    always @(posedge CLK) begin
        if (mc_start) begin
            u_busy <= 1'b1;
            u_cnt  <= BUSY_CYC;
            u_res  <= unit_calc(mc_op, mc_op1, mc_op2);
        end else if (u_busy) begin
            if (u_cnt == 1) u_busy <= 1'b0;
            u_cnt <= u_cnt - 1;
        end
    end

    assign mc_busy    = u_busy;
    assign mc_result1 = u_res[31:0];
    assign mc_result2 = u_res[63:32];

    // ---------------- ISA reference model ----------------
    function automatic logic [32:0] ref_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ps;
        logic [63:0]        pu;
        logic [31:0]        d;
        logic               e;
        logic               ovf;
        ps  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        pu  = {32'd0, a} * {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        d = '0;
        e = 1'b0;
        case (op)
            OP_MUL:    d = ps[31:0];
            OP_MULH:   d = ps[63:32];
            OP_MULHSU: e = 1'b1;
            OP_MULHU:  d = pu[63:32];
            OP_DIV: begin
                if (b == 0)   d = 32'hFFFF_FFFF;
                else if (ovf) d = a;
                else          d = $signed(a) / $signed(b);
            end
            OP_DIVU: begin
                if (b == 0) d = 32'hFFFF_FFFF;
                else        d = a / b;
            end
            OP_REM: begin
                if (b == 0)   d = a;
                else if (ovf) d = '0;
                else          d = $signed(a) % $signed(b);
            end
            default: begin
                if (b == 0) d = a;
                else        d = a % b;
            end
        endcase
        return {e, d};
    endfunction

    // ---------------- scoreboard and monitor ----------------
    typedef struct {
        logic            id;
        logic [TAGW-1:0] tag;
        logic [31:0]     data;
        logic            err;
        int              acc_cyc;
        int              lat;
    } exp_t;

    exp_t sb[$];
    int   exp_lat_p[2];

    initial begin
        logic        prev_valid;
        logic        prev_start;
        logic [37:0] snap;
        logic [32:0] r;
        exp_t        e;
        exp_t        f;
        prev_valid = 1'b0;
        prev_start = 1'b0;
        snap       = '0;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                if (req_ready != 2'b00) check("ready_onehot", $countones(req_ready), 1);
                for (int i = 0; i < 2; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        r = ref_calc(req_op[i*3 +: 3], req_a[i*WIDTH +: WIDTH], req_b[i*WIDTH +: WIDTH]);
                        e.id      = i[0];
                        e.tag     = req_tag[i*TAGW +: TAGW];
                        e.data    = r[31:0];
                        e.err     = r[32];
                        e.acc_cyc = cyc;
                        e.lat     = exp_lat_p[i];
                        sb.push_back(e);
                    end
                end
                if (mc_start) begin
                    start_cnt++;
                    check("start_single_cycle", prev_start, 0);
                end
                if (resp_valid && !prev_valid) begin
                    check("resp_expected", sb.size() != 0, 1);
                    if (sb.size() != 0) check("resp_latency", cyc - sb[0].acc_cyc, sb[0].lat);
                    snap = {resp_id, resp_tag, resp_data, resp_err};
                end else if (resp_valid && prev_valid) begin
                    check("resp_stable", {resp_id, resp_tag, resp_data, resp_err}, snap);
                end
                if (resp_valid && resp_ready && sb.size() != 0) begin
                    f = sb.pop_front();
                    check("resp_data", resp_data, f.data);
                    check("resp_id",   resp_id,   f.id);
                    check("resp_tag",  resp_tag,  f.tag);
                    check("resp_err",  resp_err,  f.err);
                end
            end
            prev_valid = resp_valid;
            prev_start = mc_start;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic sync();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input int p, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input int lat);
        req_op[p*3 +: 3]        = op;
        req_a[p*WIDTH +: WIDTH] = a;
        req_b[p*WIDTH +: WIDTH] = b;
        req_tag[p*TAGW +: TAGW] = tag;
        exp_lat_p[p]            = lat;
        req_valid[p]            = 1'b1;
    endtask

    task automatic wait_accept(input int p);
        for (int n = 0; n < 300; n++) begin
            @(negedge CLK);
            if (req_ready[p]) break;
        end
        check("accept_seen", req_ready[p], 1);
        @(posedge CLK);
        #1;
        req_valid[p] = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 400; n++) begin
            @(negedge CLK);
            if (sb.size() == 0 && !resp_valid) break;
        end
        check("drain", sb.size(), 0);
    endtask

    task automatic issue(input int p, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input int lat);
        sync();
        drive(p, op, a, b, tag, lat);
        wait_accept(p);
        wait_drain();
    endtask

    task automatic do_reset();
        sync();
        RESET = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;
        sb.delete();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int s;
        RESET      = 1'b0;
        req_valid  = 2'b01;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        req_tag    = '0;
        resp_ready = 1'b1;
        exp_lat_p[0] = 1;
        exp_lat_p[1] = 1;

        // Reset state, with a request pending to show ready stays low.
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_req_ready",  req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_err",   resp_err, 0);
        check("rst_mc_start",   mc_start, 0);
        check("rst_resp_data",  resp_data, 0);
        check("rst_resp_tag",   resp_tag, 0);
        check("rst_resp_id",    resp_id, 0);
        check("rst_mc_op",      mc_op, 0);
        check("rst_mc_op1",     mc_op1, 0);
        check("rst_mc_op2",     mc_op2, 0);
        req_valid = 2'b00;
        sync();
        RESET = 1'b1;

        // MUL through the unit, then MULH with the same operands from the cache.
        s = start_cnt;
        issue(0, OP_MUL, 32'd7, 32'hFFFF_FFFD, 4'd1, UNIT_LAT + 2);
        check("mul_started", start_cnt, s + 1);
        s = start_cnt;
        issue(0, OP_MULH, 32'd7, 32'hFFFF_FFFD, 4'd2, 1);
        check("mulh_hit_no_start", start_cnt, s);

        // Both ports at once: port 0 first after reset, port 1 then hits the cache.
        do_reset();
        drive(0, OP_DIVU, 32'd100, 32'd7, 4'd3, UNIT_LAT + 2);
        drive(1, OP_REMU, 32'd100, 32'd7, 4'd4, 1);
        for (int n = 0; n < 50; n++) begin
            @(negedge CLK);
            if (req_ready != 2'b00) break;
        end
        check("rr_first_port0", req_ready, 2'b01);
        @(posedge CLK);
        #1;
        req_valid[0] = 1'b0;
        wait_accept(1);
        wait_drain();

        // Special cases resolved without the unit.
        s = start_cnt;
        issue(0, OP_DIV, 32'd5, 32'd0, 4'd5, 1);
        issue(1, OP_REM, 32'd5, 32'd0, 4'd6, 1);
        issue(0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 4'd7, 1);
        issue(1, OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 4'd8, 1);
        issue(0, OP_DIVU, 32'd9, 32'd0, 4'd9, 1);
        check("special_no_start", start_cnt, s);

        // MULHSU error response held under back-pressure.
        resp_ready = 1'b0;
        sync();
        drive(1, OP_MULHSU, 32'd3, 32'd4, 4'd10, 1);
        wait_accept(1);
        for (int n = 0; n < 20; n++) begin
            if (resp_valid) break;
            @(negedge CLK);
        end
        repeat (5) @(negedge CLK);
        check("hold_valid", resp_valid, 1);
        check("hold_err", resp_err, 1);
        @(posedge CLK);
        #1;
        resp_ready = 1'b1;
        wait_drain();

        // Reset during WAIT abandons the operation; the repeat misses the cache.
        sync();
        drive(0, OP_MULHU, 32'd11, 32'd13, 4'd11, UNIT_LAT + 2);
        wait_accept(0);
        for (int n = 0; n < 50; n++) begin
            if (mc_start) break;
            @(negedge CLK);
        end
        check("abandon_start_seen", mc_start, 1);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        sb.delete();
        @(negedge CLK);
        check("abandon_no_valid", resp_valid, 0);
        check("abandon_op1_cleared", mc_op1, 0);
        repeat (12) @(negedge CLK);
        check("abandon_still_idle", resp_valid, 0);
        s = start_cnt;
        issue(0, OP_MULHU, 32'd11, 32'd13, 4'd12, UNIT_LAT + 2);
        check("repeat_misses_cache", start_cnt, s + 1);

        repeat (3) @(posedge CLK);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_chk, n_err);
        $fatal(1);
    end

endmodule
